stopwatch_ctrl: RTL and testbench

Sequencing controller for the stopwatch BCD counter. It takes the three debounced button levels and the counter's current 4-digit BCD value. It generates the counter's advance, direction and clear controls from a prescaled time tick, and enforces terminal-count stop in both directions. It also provides a lap (split) hold of the displayed value, and sits between the debouncers and the counter/4-digit display.

---
 rtl/stopwatch_pkg.sv | 49 ++++
 rtl/stopwatch_ctrl_tick_prescaler.sv | 51 +++++
 rtl/stopwatch_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// ---------------------------------------------------------------------------
// stopwatch_pkg
//
// Shared definitions for the stopwatch sequencing controller:
//   - state_t    : controller states (IDLE, RUN, PAUSE, LAP)
//   - cmd_t      : button command after priority resolution
//   - BCD_MAX    : terminal value when counting up   (16'h9999)
//   - BCD_ZERO   : terminal value when counting down (16'h0000)
//   - decodeCmd  : collapses simultaneous button edges to one command,
//                  priority BTNS > BTND > BTNU
// ---------------------------------------------------------------------------
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        LAP   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CMD_NONE  = 2'd0,
        CMD_START = 2'd1,
        CMD_CLEAR = 2'd2,
        CMD_DIR   = 2'd3
    } cmd_t;

    localparam logic [15:0] BCD_MAX  = 16'h9999;
    localparam logic [15:0] BCD_ZERO = 16'h0000;

    // Only one command is ever acted on per cycle; lower-priority edges that
    // coincide with a higher-priority one are simply dropped.
    function automatic cmd_t decodeCmd(input logic edgeStart,
                                       input logic edgeClear,
                                       input logic edgeDir);
        cmd_t cmd;
        if (edgeStart) begin
            cmd = CMD_START;
        end else if (edgeClear) begin
            cmd = CMD_CLEAR;
        end else if (edgeDir) begin
            cmd = CMD_DIR;
        end else begin
            cmd = CMD_NONE;
        end
        return cmd;
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_tick_prescaler.sv
// ---------------------------------------------------------------------------
// tick_prescaler
//
// Divides the system clock down to the counter advance rate. The counter only
// runs while 'run' is high and is held at zero otherwise, so every start of
// the stopwatch begins a full tick period.
//
// Parameters:
//   TICK_DIV : clock cycles per tick (>= 2)
//   TICK_W   : counter width, 2^TICK_W >= TICK_DIV
// Ports:
//   CLK  in  : system clock
//   RST  in  : synchronous active-high reset
//   run  in  : enable; counter cleared while low
//   tick out : combinational, high while the counter sits at TICK_DIV-1
// ---------------------------------------------------------------------------
module tick_prescaler #(
    parameter int TICK_DIV = 1000000,
    parameter int TICK_W   = 20
) (
    input  logic CLK,
    input  logic RST,
    input  logic run,
    output logic tick
);

    localparam logic [TICK_W-1:0] LAST = TICK_W'(TICK_DIV - 1);

    logic [TICK_W-1:0] r_count;
    logic              w_atLast;

    assign w_atLast = (r_count == LAST);

    // Free-running modulo-TICK_DIV counter while enabled. Dropping 'run'
    // zeroes it on the next edge so a paused stopwatch loses any partial
    // tick it had accumulated.
    always_ff @(posedge CLK) begin
        if (RST || !run) begin
            r_count <= '0;
        end else if (w_atLast) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    // Gated with 'run' so a counter still at LAST in the cycle 'run' falls
    // can never leak a stray tick.
    assign tick = run && w_atLast;

endmodule

// File: rtl/stopwatch_ctrl.sv
// ---------------------------------------------------------------------------
// stopwatch_ctrl
//
// Sequencing controller sitting between the button debouncers and the BCD
// counter / 4-digit display. Turns button presses into counter advance,
// direction and clear controls, stops at the terminal count in either
// direction, and optionally freezes the display for a lap (split) time.
//
// Optional feature macro: STOPWATCH_LAP_EN
//   defined     : LAP state and lap register exist; BTND in RUN takes a lap
//   not defined : no lap support; BTND in RUN is ignored, lap_hold is 0 and
//                 disp_val always follows count
//
// Parameters:
//   TICK_DIV : clock cycles per counter advance (>= 2)
//   TICK_W   : prescaler width, 2^TICK_W >= TICK_DIV
// Ports:
//   CLK      in   system clock
//   RST      in   synchronous active-high reset
//   BTNU     in   debounced level, direction toggle
//   BTNS     in   debounced level, start / pause
//   BTND     in   debounced level, clear / lap
//   count    in   current counter value, 4 BCD digits
//   cnt_en   out  one-cycle advance pulse to the counter
//   cnt_up   out  count direction, 1 = up
//   cnt_clr  out  synchronous clear to the counter
//   disp_val out  registered value for the display
//   running  out  high in RUN or LAP
//   lap_hold out  high in LAP
//   done     out  sticky terminal-count flag
// ---------------------------------------------------------------------------
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = 1000000,
    parameter int TICK_W   = 20
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        BTNU,
    input  logic        BTNS,
    input  logic        BTND,
    input  logic [15:0] count,
    output logic        cnt_en,
    output logic        cnt_up,
    output logic        cnt_clr,
    output logic [15:0] disp_val,
    output logic        running,
    output logic        lap_hold,
    output logic        done
);

    state_t      r_state;
    logic [2:0]  r_btnPrev;
    logic        r_cntUp;
    logic        r_cntClr;
    logic        r_done;
    logic        r_running;
    logic [15:0] r_disp;

`ifdef STOPWATCH_LAP_EN
    logic        r_lapHold;
    logic [15:0] r_lap;
`endif

    logic [2:0]  w_btnEdge;
    cmd_t        w_cmd;
    logic        w_run;
    logic        w_tick;
    logic        w_terminal;
    logic        w_termStop;

    // Button history, ordered {BTNU, BTNS, BTND}. Reset to all ones so a
    // button that is already held when reset releases is not seen as a press.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_btnPrev <= 3'b111;
        end else begin
            r_btnPrev <= {BTNU, BTNS, BTND};
        end
    end

    assign w_btnEdge = {BTNU, BTNS, BTND} & ~r_btnPrev;
    assign w_cmd     = decodeCmd(w_btnEdge[1], w_btnEdge[0], w_btnEdge[2]);

    // The prescaler only runs while the stopwatch is counting; LAP keeps
    // counting even though the display is frozen.
    assign w_run = (r_state == RUN) || (r_state == LAP);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV),
        .TICK_W   (TICK_W)
    ) u_prescaler (
        .CLK  (CLK),
        .RST  (RST),
        .run  (w_run),
        .tick (w_tick)
    );

    // A tick that lands on the terminal value in the current direction is
    // swallowed and turned into a stop. cnt_en is combinational from the
    // prescaler so the first advance lands exactly TICK_DIV cycles after the
    // start press; w_tick is already gated by RUN/LAP.
    assign w_terminal = r_cntUp ? (count == BCD_MAX) : (count == BCD_ZERO);
    assign w_termStop = w_tick && w_terminal;
    assign cnt_en     = w_tick && !w_terminal;

    // Main controller. A terminal stop takes precedence over any button
    // command in the same cycle, since it means the count cannot legally
    // continue. Otherwise the resolved command is interpreted per state.
    // cnt_clr defaults low each cycle so a clear is exactly one cycle wide,
    // and reset holds it high so the counter is cleared alongside us.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= IDLE;
            r_cntUp   <= 1'b1;
            r_cntClr  <= 1'b1;
            r_done    <= 1'b0;
            r_running <= 1'b0;
`ifdef STOPWATCH_LAP_EN
            r_lapHold <= 1'b0;
            r_lap     <= BCD_ZERO;
`endif
        end else begin
            r_cntClr <= 1'b0;
            if (w_termStop) begin
                r_state   <= PAUSE;
                r_running <= 1'b0;
                r_done    <= 1'b1;
`ifdef STOPWATCH_LAP_EN
                r_lapHold <= 1'b0;
`endif
            end else begin
                case (r_state)
                    IDLE, PAUSE: begin
                        case (w_cmd)
                            CMD_START: begin
                                r_state   <= RUN;
                                r_running <= 1'b1;
                                r_done    <= 1'b0;
                            end
                            CMD_CLEAR: begin
                                r_state  <= IDLE;
                                r_cntClr <= 1'b1;
                                r_done   <= 1'b0;
                            end
                            CMD_DIR: begin
                                r_cntUp <= ~r_cntUp;
                            end
                            default: begin
                            end
                        endcase
                    end
                    RUN: begin
                        case (w_cmd)
                            CMD_START: begin
                                r_state   <= PAUSE;
                                r_running <= 1'b0;
                            end
`ifdef STOPWATCH_LAP_EN
                            CMD_CLEAR: begin
                                r_state   <= LAP;
                                r_lapHold <= 1'b1;
                                r_lap     <= count;
                            end
`endif
                            default: begin
                            end
                        endcase
                    end
`ifdef STOPWATCH_LAP_EN
                    LAP: begin
                        case (w_cmd)
                            CMD_START: begin
                                r_state   <= PAUSE;
                                r_running <= 1'b0;
                                r_lapHold <= 1'b0;
                            end
                            CMD_CLEAR: begin
                                r_state   <= RUN;
                                r_lapHold <= 1'b0;
                            end
                            default: begin
                            end
                        endcase
                    end
`endif
                    default: begin
                        r_state   <= IDLE;
                        r_running <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Display register: one cycle behind count, or the captured lap value
    // while a lap is being held.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_disp <= BCD_ZERO;
        end else begin
`ifdef STOPWATCH_LAP_EN
            r_disp <= (r_state == LAP) ? r_lap : count;
`else
            r_disp <= count;
`endif
        end
    end

    assign cnt_up   = r_cntUp;
    assign cnt_clr  = r_cntClr;
    assign disp_val = r_disp;
    assign running  = r_running;
    assign done     = r_done;
`ifdef STOPWATCH_LAP_EN
    assign lap_hold = r_lapHold;
`else
    assign lap_hold = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_stopwatch_ctrl
//
// Bench for stopwatch_ctrl with TICK_DIV = 4. A small BCD counter model
// responds to cnt_en / cnt_clr and can be preset. Expected cnt_en and
// cnt_clr pulses are queued with hand-computed cycle numbers and count
// values; a negedge monitor pops and compares each pulse the DUT produces.
// Static outputs are checked at chosen cycles against hand-computed values.
// ---------------------------------------------------------------------------
module tb_stopwatch_ctrl;

    localparam int TICK_DIV = 4;
    localparam int TICK_W   = 3;

`ifdef STOPWATCH_LAP_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    logic        CLK  = 1'b0;
    logic        RST  = 1'b1;
    logic        BTNU = 1'b0;
    logic        BTNS = 1'b0;
    logic        BTND = 1'b0;
    logic [15:0] count = 16'h0000;
    logic        cnt_en;
    logic        cnt_up;
    logic        cnt_clr;
    logic [15:0] disp_val;
    logic        running;
    logic        lap_hold;
    logic        done;

    int          cyc = 0;
    int          assertCount = 0;
    int          failCount = 0;
    logic        presetReq = 1'b0;
    logic [15:0] presetVal = 16'h0000;

    typedef struct {
        int          cycle;
        logic [15:0] value;
        logic        up;
    } enEvent_t;

    enEvent_t enQ[$];
    int       clrQ[$];

    stopwatch_ctrl #(
        .TICK_DIV (TICK_DIV),
        .TICK_W   (TICK_W)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .BTNU     (BTNU),
        .BTNS     (BTNS),
        .BTND     (BTND),
        .count    (count),
        .cnt_en   (cnt_en),
        .cnt_up   (cnt_up),
        .cnt_clr  (cnt_clr),
        .disp_val (disp_val),
        .running  (running),
        .lap_hold (lap_hold),
        .done     (done)
    );

    always #5 CLK = ~CLK;

    // Cycle n is the interval following the n-th rising edge.
    always @(posedge CLK) begin
        cyc <= cyc + 1;
    end

    function automatic logic [15:0] bcdStep(input logic [15:0] v, input logic up);
        logic [15:0] r;
        r = v;
        for (int i = 0; i < 4; i++) begin
            if (up) begin
                if (r[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    return r;
                end
            end else begin
                if (r[i*4 +: 4] == 4'd0) begin
                    r[i*4 +: 4] = 4'd9;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] - 4'd1;
                    return r;
                end
            end
        end
        return r;
    endfunction

    // External BCD counter the controller drives.
    always @(posedge CLK) begin
        if (presetReq) begin
            count <= presetVal;
        end else if (cnt_clr === 1'b1) begin
            count <= 16'h0000;
        end else if (cnt_en === 1'b1) begin
            count <= bcdStep(count, cnt_up);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    task automatic reportFail(input string name, input string detail);
        assertCount++;
        failCount++;
        $display("[TB] FAIL %s: %s (cycle %0d)", name, detail, cyc);
    endtask

    task automatic atCycle(input int n);
        while (cyc < n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic checkAt(input int n);
        atCycle(n);
        @(negedge CLK);
    endtask

    task automatic applyStimulus(input int n, input logic u, input logic s, input logic d);
        atCycle(n);
        BTNU = u;
        BTNS = s;
        BTND = d;
        atCycle(n + 2);
        BTNU = 1'b0;
        BTNS = 1'b0;
        BTND = 1'b0;
    endtask

    task automatic presetCount(input int n, input logic [15:0] v);
        atCycle(n);
        presetVal = v;
        presetReq = 1'b1;
        atCycle(n + 1);
        presetReq = 1'b0;
    endtask

    task automatic pushEn(input int c, input logic [15:0] v, input logic up);
        enEvent_t e;
        e.cycle = c;
        e.value = v;
        e.up    = up;
        enQ.push_back(e);
    endtask

    // Scoreboard monitor: every cnt_en / cnt_clr pulse outside reset must
    // match the next queued expectation.
    always @(negedge CLK) begin
        if (RST === 1'b0) begin
            if (cnt_en === 1'b1) begin
                if (enQ.size() == 0) begin
                    reportFail("cnt_en unexpected", "pulse with empty queue");
                end else begin
                    enEvent_t e;
                    e = enQ.pop_front();
                    checkOutput("cnt_en cycle", cyc, e.cycle);
                    checkOutput("cnt_en count", {16'h0, count}, {16'h0, e.value});
                    checkOutput("cnt_en dir", {31'h0, cnt_up}, {31'h0, e.up});
                end
            end
            if (cnt_clr === 1'b1) begin
                if (clrQ.size() == 0) begin
                    reportFail("cnt_clr unexpected", "pulse with empty queue");
                end else begin
                    int c;
                    c = clrQ.pop_front();
                    checkOutput("cnt_clr cycle", cyc, c);
                end
            end
        end
    end

    initial begin
        #20000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset and reset values
        clrQ.push_back(3);
        atCycle(3);
        RST = 1'b0;
        checkAt(3);
        checkOutput("reset running", {31'h0, running}, 32'h0);
        checkOutput("reset done", {31'h0, done}, 32'h0);
        checkOutput("reset cnt_up", {31'h0, cnt_up}, 32'h1);
        checkOutput("reset lap_hold", {31'h0, lap_hold}, 32'h0);
        checkOutput("reset disp_val", {16'h0, disp_val}, 32'h0);
        checkOutput("reset cnt_en", {31'h0, cnt_en}, 32'h0);

        // Start at cycle 10, pulses every 4 cycles
        pushEn(14, 16'h0000, 1'b1);
        pushEn(18, 16'h0001, 1'b1);
        pushEn(22, 16'h0002, 1'b1);
        applyStimulus(10, 1'b0, 1'b1, 1'b0);
        checkAt(12);
        checkOutput("run running", {31'h0, running}, 32'h1);

        // Pause at count 3, then clear, then direction toggle
        applyStimulus(24, 1'b0, 1'b1, 1'b0);
        checkAt(26);
        checkOutput("pause running", {31'h0, running}, 32'h0);
        checkOutput("pause disp_val", {16'h0, disp_val}, 32'h0003);
        clrQ.push_back(33);
        applyStimulus(32, 1'b0, 1'b0, 1'b1);
        checkAt(35);
        checkOutput("clear disp_val", {16'h0, disp_val}, 32'h0000);
        checkOutput("clear running", {31'h0, running}, 32'h0);
        applyStimulus(38, 1'b1, 1'b0, 1'b0);
        checkAt(40);
        checkOutput("toggle cnt_up", {31'h0, cnt_up}, 32'h0);

        // Count down from 2 to terminal 0
        presetCount(42, 16'h0002);
        pushEn(50, 16'h0002, 1'b0);
        pushEn(54, 16'h0001, 1'b0);
        applyStimulus(46, 1'b0, 1'b1, 1'b0);
        checkAt(58);
        checkOutput("down terminal cnt_en", {31'h0, cnt_en}, 32'h0);
        checkOutput("down terminal running before", {31'h0, running}, 32'h1);
        checkAt(60);
        checkOutput("down done", {31'h0, done}, 32'h1);
        checkOutput("down running", {31'h0, running}, 32'h0);
        checkOutput("down disp_val", {16'h0, disp_val}, 32'h0000);

        // Count up from 9998 to terminal 9999
        applyStimulus(62, 1'b1, 1'b0, 1'b0);
        presetCount(64, 16'h9998);
        pushEn(72, 16'h9998, 1'b1);
        applyStimulus(68, 1'b0, 1'b1, 1'b0);
        checkAt(70);
        checkOutput("up restart done", {31'h0, done}, 32'h0);
        checkOutput("up restart running", {31'h0, running}, 32'h1);
        checkAt(76);
        checkOutput("up terminal cnt_en", {31'h0, cnt_en}, 32'h0);
        checkAt(78);
        checkOutput("up done", {31'h0, done}, 32'h1);
        checkOutput("up running", {31'h0, running}, 32'h0);
        checkOutput("up disp_val", {16'h0, disp_val}, 32'h9999);

        // Start at terminal: stops on the first tick
        applyStimulus(80, 1'b0, 1'b1, 1'b0);
        checkAt(82);
        checkOutput("term start done", {31'h0, done}, 32'h0);
        checkOutput("term start running", {31'h0, running}, 32'h1);
        checkAt(84);
        checkOutput("term start cnt_en", {31'h0, cnt_en}, 32'h0);
        checkAt(86);
        checkOutput("term stop done", {31'h0, done}, 32'h1);
        checkOutput("term stop running", {31'h0, running}, 32'h0);

        // Lap: BTND in RUN at count 0042
        clrQ.push_back(89);
        applyStimulus(88, 1'b0, 1'b0, 1'b1);
        presetCount(92, 16'h0042);
        pushEn(100, 16'h0042, 1'b1);
        pushEn(104, 16'h0043, 1'b1);
        pushEn(108, 16'h0044, 1'b1);
        pushEn(112, 16'h0045, 1'b1);
        pushEn(116, 16'h0046, 1'b1);
        applyStimulus(96, 1'b0, 1'b1, 1'b0);
        applyStimulus(98, 1'b0, 1'b0, 1'b1);
        checkAt(106);
        checkOutput("lap disp_val", {16'h0, disp_val}, LAP_EN ? 32'h0042 : 32'h0044);
        checkOutput("lap lap_hold", {31'h0, lap_hold}, {31'h0, LAP_EN});
        checkOutput("lap running", {31'h0, running}, 32'h1);
        applyStimulus(107, 1'b0, 1'b0, 1'b1);
        checkAt(111);
        checkOutput("lap release disp_val", {16'h0, disp_val}, 32'h0045);
        checkOutput("lap release lap_hold", {31'h0, lap_hold}, 32'h0);
        applyStimulus(117, 1'b0, 1'b1, 1'b0);
        checkAt(120);
        checkOutput("lap pause running", {31'h0, running}, 32'h0);
        checkOutput("lap pause cnt_en", {31'h0, cnt_en}, 32'h0);

        // Simultaneous BTNS and BTND in IDLE: start only, no clear
        clrQ.push_back(123);
        applyStimulus(122, 1'b0, 1'b0, 1'b1);
        pushEn(130, 16'h0000, 1'b1);
        pushEn(134, 16'h0001, 1'b1);
        applyStimulus(126, 1'b0, 1'b1, 1'b1);
        checkAt(128);
        checkOutput("simul running", {31'h0, running}, 32'h1);
        checkOutput("simul lap_hold", {31'h0, lap_hold}, 32'h0);
        applyStimulus(135, 1'b0, 1'b1, 1'b0);

        // BTNS held through reset must not start the stopwatch
        atCycle(140);
        clrQ.push_back(143);
        BTNS = 1'b1;
        RST  = 1'b1;
        atCycle(143);
        RST  = 1'b0;
        checkAt(145);
        checkOutput("held reset running", {31'h0, running}, 32'h0);
        checkOutput("held reset done", {31'h0, done}, 32'h0);
        checkOutput("held reset cnt_up", {31'h0, cnt_up}, 32'h1);
        atCycle(150);
        BTNS = 1'b0;
        checkAt(160);
        checkOutput("held release running", {31'h0, running}, 32'h0);

        // Every queued pulse must have been seen
        checkAt(165);
        checkOutput("cnt_en events left", enQ.size(), 32'h0);
        checkOutput("cnt_clr events left", clrQ.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertCount, failCount);
        $finish;
    end

endmodule
